// File: rtl/demux_pkg.sv
// Shared definitions for the clocked 1-to-2 demultiplexer.
// Select encodings used by the top-level decode.
package demux_pkg;

  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

endpackage

// File: rtl/demux_out_reg.sv
// One registered output lane of the demux.
// Loads {i, 1} when enabled, otherwise {0, 0}, so stale data is never held.
module demux_out_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] d,
  output logic             vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d   <= '0;
      vld <= 1'b0;
    end else if (en) begin
      d   <= i;
      vld <= 1'b1;
    end else begin
      d   <= '0;
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_2.sv
// Clocked 1-to-2 demultiplexer: routes i to d0 or d1 under s, one pipeline stage.
// The non-selected lane is driven to zero every cycle.
module demux_1_2
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic             i_vld,
  input  logic             s,
  output logic [WIDTH-1:0] d0,
  output logic             d0_vld,
  output logic [WIDTH-1:0] d1,
  output logic             d1_vld
);

  logic sel;
  logic en0;
  logic en1;

  // Anything other than a clean 1 on s (including X) falls through to d0.
  always_comb begin
    sel = SEL_D0;
    if (s == SEL_D1) sel = SEL_D1;
  end

  assign en0 = i_vld & (sel == SEL_D0);
  assign en1 = i_vld & (sel == SEL_D1);

  demux_out_reg #(.WIDTH(WIDTH)) u_out0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en0),
    .i     (i),
    .d     (d0),
    .vld   (d0_vld)
  );

  demux_out_reg #(.WIDTH(WIDTH)) u_out1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en1),
    .i     (i),
    .d     (d1),
    .vld   (d1_vld)
  );

  a_one_hot_vld : assert property (@(posedge clk) disable iff (!rst_n) !(d0_vld && d1_vld));

endmodule

// File: tb/tb_demux_1_2.sv
// Bench for demux_1_2: vector table, reset corner cases and a random run
// checked against a behavioural routing model (WIDTH=8 and WIDTH=1 instances).
module tb_demux_1_2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i;
  logic       i_vld;
  logic       s;
  logic [7:0] d0, d1;
  logic       d0_vld, d1_vld;
  logic       n_d0, n_d1, n_d0_vld, n_d1_vld;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] d0;
    logic       d0_vld;
    logic [7:0] d1;
    logic       d1_vld;
  } out_t;

  typedef struct {
    logic       vld;
    logic       sel;
    logic [7:0] data;
    out_t       exp;
    string      name;
  } vec_t;

  out_t prev_exp;
  vec_t vecs[$];

  always #5 clk = ~clk;

  demux_1_2 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i      (i),
    .i_vld  (i_vld),
    .s      (s),
    .d0     (d0),
    .d0_vld (d0_vld),
    .d1     (d1),
    .d1_vld (d1_vld)
  );

  demux_1_2 #(.WIDTH(1)) dut_w1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i      (i[0]),
    .i_vld  (i_vld),
    .s      (s),
    .d0     (n_d0),
    .d0_vld (n_d0_vld),
    .d1     (n_d1),
    .d1_vld (n_d1_vld)
  );

  // Reference: a valid word lands on the lane named by s, everything else is zero.
  function automatic out_t model(input logic vld, input logic sel, input logic [7:0] data);
    out_t o;
    o = '0;
    if (vld) begin
      if (sel) begin
        o.d1     = data;
        o.d1_vld = 1'b1;
      end else begin
        o.d0     = data;
        o.d0_vld = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic vec_t mk(input logic vld, input logic sel, input logic [7:0] data,
                              input logic [7:0] e_d0, input logic e_d0v,
                              input logic [7:0] e_d1, input logic e_d1v, input string name);
    vec_t v;
    v.vld        = vld;
    v.sel        = sel;
    v.data       = data;
    v.exp.d0     = e_d0;
    v.exp.d0_vld = e_d0v;
    v.exp.d1     = e_d1;
    v.exp.d1_vld = e_d1v;
    v.name       = name;
    return v;
  endfunction

  task automatic chk(input string name, input out_t e);
    out_t act;
    act = {d0, d0_vld, d1, d1_vld};
    n_tests++;
    if (act !== e || n_d0 !== e.d0[0] || n_d0_vld !== e.d0_vld ||
        n_d1 !== e.d1[0] || n_d1_vld !== e.d1_vld) begin
      n_fail++;
      $display("FAIL %s: got d0=%h d0_vld=%b d1=%h d1_vld=%b (w1 d0=%b v=%b d1=%b v=%b), expected d0=%h d0_vld=%b d1=%h d1_vld=%b",
               name, d0, d0_vld, d1, d1_vld, n_d0, n_d0_vld, n_d1, n_d1_vld,
               e.d0, e.d0_vld, e.d1, e.d1_vld);
    end
    n_tests++;
    if ((d0_vld && d1_vld) || (n_d0_vld && n_d1_vld)) begin
      n_fail++;
      $display("FAIL %s_onehot: got d0_vld=%b d1_vld=%b (w1 %b %b), expected at most one high",
               name, d0_vld, d1_vld, n_d0_vld, n_d1_vld);
    end
  endtask

  // Outputs must still show the previous word before the edge, the new one after it.
  task automatic step(input string name, input logic vld, input logic sel,
                      input logic [7:0] data, input out_t e);
    i_vld = vld;
    s     = sel;
    i     = data;
    #1;
    chk({name, "_pre"}, prev_exp);
    @(posedge clk);
    #1;
    chk(name, e);
    prev_exp = e;
  endtask

  initial begin
    rst_n    = 1'b1;
    i        = '0;
    i_vld    = 1'b0;
    s        = 1'b0;
    prev_exp = '0;

    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "w1_s0_i0"));
    vecs.push_back(mk(1'b1, 1'b0, 8'h01, 8'h01, 1'b1, 8'h00, 1'b0, "w1_s0_i1"));
    vecs.push_back(mk(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, "w1_s1_i0"));
    vecs.push_back(mk(1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b1, "w1_s1_i1"));
    vecs.push_back(mk(1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1, 8'h00, 1'b0, "alt_a5"));
    vecs.push_back(mk(1'b1, 1'b1, 8'h3C, 8'h00, 1'b0, 8'h3C, 1'b1, "alt_3c"));
    vecs.push_back(mk(1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1, 8'h00, 1'b0, "alt_a5_2"));
    vecs.push_back(mk(1'b1, 1'b1, 8'h3C, 8'h00, 1'b0, 8'h3C, 1'b1, "alt_3c_2"));
    vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, "idle_ff"));
    vecs.push_back(mk(1'b1, 1'b1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b1, "b2b_1"));
    vecs.push_back(mk(1'b1, 1'b1, 8'h02, 8'h00, 1'b0, 8'h02, 1'b1, "b2b_2"));
    vecs.push_back(mk(1'b1, 1'b1, 8'h03, 8'h00, 1'b0, 8'h03, 1'b1, "b2b_3"));
    vecs.push_back(mk(1'b1, 1'b1, 8'h04, 8'h00, 1'b0, 8'h04, 1'b1, "b2b_4"));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, "idle_ff_s0"));

    #1 rst_n = 1'b0;
    #1 chk("reset", '0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", '0);
    rst_n = 1'b1;

    foreach (vecs[k]) step(vecs[k].name, vecs[k].vld, vecs[k].sel, vecs[k].data, vecs[k].exp);

    // Asynchronous reset with a word on the output and traffic still arriving.
    step("pre_rst", 1'b1, 1'b1, 8'h77, model(1'b1, 1'b1, 8'h77));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", '0);
    i_vld = 1'b1;
    s     = 1'b0;
    i     = 8'h11;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 chk("rst_held", '0);
    end
    rst_n    = 1'b1;
    prev_exp = '0;
    step("post_rst", 1'b1, 1'b0, 8'h5A, model(1'b1, 1'b0, 8'h5A));

    for (int k = 0; k < 1000; k++) begin
      logic       rv, rs;
      logic [7:0] ri;
      rv = ($urandom % 4) != 0;
      rs = $urandom_range(0, 1);
      ri = 8'($urandom);
      step("rand", rv, rs, ri, model(rv, rs, ri));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
